// File: rtl/line_pkg.sv
// Shared types, state encodings and helpers for the line pixel writer.
package line_pkg;

    localparam int unsigned COORD_W         = 16;
    localparam int unsigned COUNT_W         = COORD_W + 1;
    localparam int unsigned BYTES_PER_PIXEL = 4;
    localparam int unsigned BYTE_SHIFT      = $clog2(BYTES_PER_PIXEL);
    localparam int unsigned STATE_W         = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] CALC   = 3'd1;
    localparam logic [STATE_W-1:0] SETTLE = 3'd2;
    localparam logic [STATE_W-1:0] SAMPLE = 3'd3;
    localparam logic [STATE_W-1:0] WRITE  = 3'd4;
    localparam logic [STATE_W-1:0] NEXT   = 3'd5;
    localparam logic [STATE_W-1:0] DONE   = 3'd6;

    // Latched line command handed to the rasteriser.
    typedef struct packed {
        coord_t x1;
        coord_t y1;
        coord_t x2;
        coord_t y2;
    } line_cmd_t;

    // |b - a| using one extra bit so the full 16-bit range cannot overflow.
    function automatic count_t abs_diff(input coord_t a, input coord_t b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, b}) - $signed({1'b0, a});
        return d[COORD_W] ? count_t'(-d) : count_t'(d);
    endfunction

    // Number of pixels the rasteriser emits for a line: max(|dx|,|dy|)+1.
    function automatic count_t line_count(input coord_t x1, input coord_t y1,
                                          input coord_t x2, input coord_t y2);
        count_t ax;
        count_t ay;
        ax = abs_diff(x1, x2);
        ay = abs_diff(y1, y2);
        return ((ax > ay) ? ax : ay) + count_t'(1);
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer byte address: base + ((y*SCREEN_W + x) << log2(bytes per pixel)).
// Arithmetic is carried out modulo 2^ADDR_W, so the result wraps naturally.
module fb_addr_calc
    import line_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic [ADDR_W-1:0]  base,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr_c
);

    localparam logic [31:0] SW_BITS = 32'(SCREEN_W);

    logic [ADDR_W-1:0] lin;

    // Constant multiply by SCREEN_W as a shift-and-add over its set bits.
    always_comb begin
        lin = '0;
        for (int i = 0; i < 32; i++) begin
            if (SW_BITS[i]) begin
                lin = lin + (ADDR_W'(y) << i);
            end
        end
        lin    = lin + ADDR_W'(x);
        addr_c = base + (lin << BYTE_SHIFT);
    end

endmodule

// File: rtl/line_pixel_writer.sv
// Drives the line rasteriser and writes each returned pixel to the framebuffer.
// Define LINE_CLIP_EN to drop pixels outside SCREEN_W x SCREEN_H.
module line_pixel_writer
    import line_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned COLOR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COLOR_W-1:0] color,
    input  logic [ADDR_W-1:0]  fb_base,
    output logic               busy,
    output logic               done,
    output logic               calculate,
    output logic               get_pixel,
    output logic [COORD_W-1:0] ras_x1,
    output logic [COORD_W-1:0] ras_y1,
    output logic [COORD_W-1:0] ras_x2,
    output logic [COORD_W-1:0] ras_y2,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [COLOR_W-1:0] mem_writedata,
    input  logic               mem_waitrequest
);

`ifdef LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    line_cmd_t          cmd_q, cmd_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    count_t             count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               calc_q, calc_d;
    logic               gp_q, gp_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [COLOR_W-1:0] mem_writedata_q, mem_writedata_d;

    logic [ADDR_W-1:0]  pix_addr_c;
    logic               on_screen_c;
    logic               pix_visible_c;

    fb_addr_calc #(
        .SCREEN_W (SCREEN_W),
        .ADDR_W   (ADDR_W)
    ) u_addr (
        .base   (base_q),
        .x      (px),
        .y      (py),
        .addr_c (pix_addr_c)
    );

    // Without clipping every pixel is written and the address simply wraps.
    always_comb begin
        on_screen_c   = (32'(px) < SCREEN_W) && (32'(py) < SCREEN_H);
        pix_visible_c = !CLIP_EN || on_screen_c;
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        color_d         = color_q;
        base_d          = base_q;
        count_d         = count_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d   = '{x1: x1, y1: y1, x2: x2, y2: y2};
                    color_d = color;
                    base_d  = fb_base;
                    count_d = line_count(x1, y1, x2, y2);
                    state_d = CALC;
                end
            end
            CALC:   state_d = SETTLE;
            SETTLE: state_d = SAMPLE;
            SAMPLE: begin
                if (pix_visible_c) begin
                    mem_address_d   = pix_addr_c;
                    mem_writedata_d = color_q;
                    state_d         = WRITE;
                end else begin
                    state_d = NEXT;
                end
            end
            WRITE: begin
                if (!mem_waitrequest) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                count_d = count_q - count_t'(1);
                state_d = (count_q == count_t'(1)) ? DONE : SETTLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they line up with it.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        calc_d      = (state_d == CALC);
        gp_d        = (state_q == NEXT) && (state_d == SETTLE);
        mem_write_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cmd_q           <= '0;
            color_q         <= '0;
            base_q          <= '0;
            count_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            calc_q          <= 1'b0;
            gp_q            <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            color_q         <= color_d;
            base_q          <= base_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            calc_q          <= calc_d;
            gp_q            <= gp_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign calculate     = calc_q;
    assign get_pixel     = gp_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign ras_x1        = cmd_q.x1;
    assign ras_y1        = cmd_q.y1;
    assign ras_x2        = cmd_q.x2;
    assign ras_y2        = cmd_q.y2;

endmodule

// File: tb/tb_line_pixel_writer.sv
// Bench for line_pixel_writer: Bresenham rasteriser model, write monitor,
// table of directed lines plus stall and mid-line reset sequences.
module tb_line_pixel_writer;

    localparam int SW = 640;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] x1, y1, x2, y2;
    logic [31:0] color;
    logic [31:0] fb_base;
    logic        busy, done, calculate, get_pixel;
    logic [15:0] ras_x1, ras_y1, ras_x2, ras_y2;
    logic [15:0] px, py;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;

    line_pixel_writer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .x1              (x1),
        .y1              (y1),
        .x2              (x2),
        .y2              (y2),
        .color           (color),
        .fb_base         (fb_base),
        .busy            (busy),
        .done            (done),
        .calculate       (calculate),
        .get_pixel       (get_pixel),
        .ras_x1          (ras_x1),
        .ras_y1          (ras_y1),
        .ras_x2          (ras_x2),
        .ras_y2          (ras_y2),
        .px              (px),
        .py              (py),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Rasteriser model: Bresenham, outputs valid the cycle after calculate/get_pixel.
    typedef struct packed {
        int x;
        int y;
        int err;
    } bres_t;

    bres_t b;
    int    bdx, bdy, bsx, bsy;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bres_t bres_step(input bres_t s, input int dx, input int dy,
                                        input int sx, input int sy);
        bres_t n;
        int    e2;
        n  = s;
        e2 = 2 * s.err;
        if (e2 >= dy) begin
            n.err = n.err + dy;
            n.x   = n.x + sx;
        end
        if (e2 <= dx) begin
            n.err = n.err + dx;
            n.y   = n.y + sy;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (calculate) begin
            b   <= '{x: int'(ras_x1), y: int'(ras_y1),
                     err: iabs(int'(ras_x2) - int'(ras_x1)) - iabs(int'(ras_y2) - int'(ras_y1))};
            bdx <= iabs(int'(ras_x2) - int'(ras_x1));
            bdy <= -iabs(int'(ras_y2) - int'(ras_y1));
            bsx <= (ras_x1 < ras_x2) ? 1 : -1;
            bsy <= (ras_y1 < ras_y2) ? 1 : -1;
        end else if (get_pixel) begin
            b <= bres_step(b, bdx, bdy, bsx, bsy);
        end
    end

    assign px = 16'(b.x);
    assign py = 16'(b.y);

    // Write monitor: checks every completed write against the current model pixel.
    logic [31:0] cmd_base;
    logic [31:0] cmd_color;
    logic [31:0] exp_addr;
    int          wr_cnt = 0, gp_cnt = 0, done_cnt = 0, calc_cnt = 0;
    int          addr_bad = 0, data_bad = 0;
    logic [31:0] addr_log[$];

    assign exp_addr = cmd_base + 32'((b.y * SW + b.x) * 4);

    always @(negedge clk) begin
        if (reset) begin
            if (mem_write && !mem_waitrequest) begin
                wr_cnt++;
                addr_log.push_back(mem_address);
                if (mem_address !== exp_addr)  addr_bad++;
                if (mem_writedata !== cmd_color) data_bad++;
            end
            if (get_pixel) gp_cnt++;
            if (done)      done_cnt++;
            if (calculate) calc_cnt++;
        end
    end

    typedef struct {
        int          x1, y1, x2, y2;
        logic [31:0] base;
        logic [31:0] color;
        int          exp_writes;
        int          exp_gp;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        bit          restart;
    } vec_t;

    vec_t vecs[8];

    task automatic issue(input vec_t v);
        @(posedge clk); #1;
        x1        = 16'(v.x1);
        y1        = 16'(v.y1);
        x2        = 16'(v.x2);
        y2        = 16'(v.y2);
        color     = v.color;
        fb_base   = v.base;
        cmd_base  = v.base;
        cmd_color = v.color;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'(1));
    endtask

    task automatic run_line(input vec_t v, input string tag);
        int w0, g0, d0, c0, ab0, db0, n0;
        w0 = wr_cnt; g0 = gp_cnt; d0 = done_cnt; c0 = calc_cnt;
        ab0 = addr_bad; db0 = data_bad; n0 = addr_log.size();
        issue(v);
        @(negedge clk);
        check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
        if (v.restart) begin
            repeat (3) @(posedge clk);
            #1;
            x1 = 16'd300; y1 = 16'd300; color = 32'h0; fb_base = 32'h0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(tag);
        @(negedge clk); #1;
        check({tag, "_busy_after_done"}, 64'(busy), 64'(0));
        check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        check({tag, "_writes"}, 64'(wr_cnt - w0), 64'(v.exp_writes));
        check({tag, "_get_pixel"}, 64'(gp_cnt - g0), 64'(v.exp_gp));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_calc_pulses"}, 64'(calc_cnt - c0), 64'(1));
        check({tag, "_addr_errs"}, 64'(addr_bad - ab0), 64'(0));
        check({tag, "_data_errs"}, 64'(data_bad - db0), 64'(0));
        if (addr_log.size() > n0) begin
            check({tag, "_first_addr"}, 64'(addr_log[n0]), 64'(v.exp_first));
            check({tag, "_last_addr"}, 64'(addr_log[addr_log.size()-1]), 64'(v.exp_last));
        end else begin
            check({tag, "_no_write"}, 64'(addr_log.size()), 64'(n0 + 1));
        end
        check({tag, "_endpoints"}, 64'({ras_x1, ras_y1, ras_x2, ras_y2}),
              64'({16'(v.x1), 16'(v.y1), 16'(v.x2), 16'(v.y2)}));
    endtask

    initial begin
        vec_t sv;
        int   w0, g0, seen;

        reset = 1'b0; start = 1'b0; mem_waitrequest = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; color = '0; fb_base = '0;
        cmd_base = '0; cmd_color = '0;

        //          x1   y1   x2   y2   base          color         wr  gp  first         last          rs
        vecs[0] = '{100, 90,  50,  100, 32'h0,        32'hDEADBEEF, 51, 50, 32'h0003_8590, 32'd256200,   1'b0};
        vecs[1] = '{10,  50,  20,  50,  32'h0,        32'h11223344, 11, 10, 32'd128040,    32'd128080,   1'b1};
        vecs[2] = '{10,  5,   10,  5,   32'h1000,     32'hCAFEF00D, 1,  0,  32'd16936,     32'd16936,    1'b0};
        vecs[3] = '{3,   0,   3,   4,   32'h100,      32'h00000005, 5,  4,  32'd268,       32'd10508,    1'b0};
        vecs[4] = '{5,   7,   2,   0,   32'h0,        32'h0BADC0DE, 8,  7,  32'd17940,     32'd8,        1'b0};
`ifdef LINE_CLIP_EN
        vecs[5] = '{630, 5,   650, 5,   32'h0,        32'h55AA55AA, 10, 20, 32'd15320,     32'd15356,    1'b0};
        vecs[7] = '{0,   479, 0,   481, 32'h0,        32'h01020304, 1,  2,  32'd1226240,   32'd1226240,  1'b0};
`else
        vecs[5] = '{630, 5,   650, 5,   32'h0,        32'h55AA55AA, 21, 20, 32'd15320,     32'd15400,    1'b0};
        vecs[7] = '{0,   479, 0,   481, 32'h0,        32'h01020304, 3,  2,  32'd1226240,   32'd1231360,  1'b0};
`endif
        vecs[6] = '{10,  0,   10,  0,   32'hFFFF_FFF0, 32'h77777777, 1, 0,  32'h18,        32'h18,       1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({busy, done, calculate, get_pixel, mem_write}), 64'(0));
        check("rst_addr", 64'(mem_address), 64'(0));
        check("rst_data", 64'(mem_writedata), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 64'({busy, calculate, mem_write}), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_line(vecs[i], $sformatf("v%0d", i));
        end

        // Back-pressure: waitrequest held for the first three cycles of the first write.
        sv = '{0, 0, 2, 0, 32'h40, 32'hA5A5A5A5, 3, 2, 32'h40, 32'h48, 1'b0};
        w0 = wr_cnt; g0 = gp_cnt;
        mem_waitrequest = 1'b1;
        issue(sv);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_write) begin
                seen = 1;
                break;
            end
        end
        check("stall_write_seen", 64'(seen), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_wr_c%0d", i), 64'(mem_write), 64'(1));
            check($sformatf("stall_addr_c%0d", i), 64'(mem_address), 64'(32'h40));
            check($sformatf("stall_data_c%0d", i), 64'(mem_writedata), 64'(32'hA5A5A5A5));
            check($sformatf("stall_nogp_c%0d", i), 64'(get_pixel), 64'(0));
            @(posedge clk);
            if (i == 2) begin
                #1;
                mem_waitrequest = 1'b0;
            end
            @(negedge clk);
        end
        check("stall_wr_released", 64'(mem_write), 64'(0));
        wait_done("stall");
        @(negedge clk); #1;
        check("stall_writes", 64'(wr_cnt - w0), 64'(3));
        check("stall_get_pixel", 64'(gp_cnt - g0), 64'(2));

        // Reset asserted during the third pixel's write aborts at once.
        sv = '{0, 0, 9, 0, 32'h0, 32'h12345678, 10, 9, 32'h0, 32'd36, 1'b0};
        issue(sv);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_write) seen++;
            if (seen == 3) break;
        end
        check("rst_mid_reached_w3", 64'(seen), 64'(3));
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({mem_write, busy, done}), 64'(0));
        check("rst_mid_addr", 64'(mem_address), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid_quiet%0d", i),
                  64'({calculate, get_pixel, mem_write, busy}), 64'(0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run_line(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/line_pixel_writer.md
Name: line_pixel_writer

Overview:
Downstream consumer of the line rasteriser (DrawLine). Takes one line command (endpoints, colour, framebuffer base) and drives the rasteriser's calculate and get_pixel controls. Converts each returned (x,y) into a framebuffer byte address and issues one memory-master write per visible pixel, with waitrequest back-pressure. Signals done when the line is complete.

Parameters:
SCREEN_W, 640, visible width in pixels; clip bound for x
SCREEN_H, 480, visible height in pixels; clip bound for y
ADDR_W, 32, memory address width
COLOR_W, 32, pixel data width; 4 bytes per pixel fixed

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle command strobe; sampled only in IDLE
x1  in  16  line start x
y1  in  16  line start y
x2  in  16  line end x
y2  in  16  line end y
color  in  COLOR_W  pixel colour, latched at start
fb_base  in  ADDR_W  framebuffer byte base, latched at start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last pixel is handled
calculate  out  1  to rasteriser: one-cycle load pulse
get_pixel  out  1  to rasteriser: one-cycle advance pulse
px  in  16  from rasteriser x_o
py  in  16  from rasteriser y_o
mem_write  out  1  write request
mem_address  out  ADDR_W  byte address
mem_writedata  out  COLOR_W  pixel data
mem_waitrequest  in  1  slave stall; write completes on a cycle with mem_write=1 and waitrequest=0

Behaviour:
- Reset: state IDLE; busy, done, calculate, get_pixel, mem_write = 0; mem_address, mem_writedata = 0; counters = 0. Reset asserted mid-line aborts immediately; mem_write drops asynchronously and no further pulses occur.
- Rasteriser contract: current pixel is valid on px/py one cycle after calculate or after each get_pixel pulse.
- FSM: IDLE -> CALC -> SETTLE -> SAMPLE -> WRITE -> NEXT -> SETTLE ... -> DONE -> IDLE.
- IDLE: on start, latch endpoints, color and fb_base. Count = max(|x2-x1|,|y2-y1|)+1, computed 17-bit unsigned; 16-bit differences use 17-bit signed arithmetic. Go to CALC.
- CALC: calculate=1 for exactly one cycle; endpoints are driven on x1..y2 passthrough from latched copies.
- SETTLE: one wait cycle.
- SAMPLE: register px/py. Visible if px<SCREEN_W and py<SCREEN_H. Address = fb_base + ((py*SCREEN_W + px) << 2), truncated to ADDR_W. Visible pixels go to WRITE; hidden pixels go to NEXT.
- WRITE: mem_write=1; address and data held stable while waitrequest=1. Leave on the first cycle with waitrequest=0.
- NEXT: decrement count. If count reaches 0, go to DONE with no get_pixel. Otherwise get_pixel=1 for one cycle, then SETTLE.
- DONE: done=1 for one cycle; busy=0 from the next cycle.
- get_pixel pulses per line = count-1. Memory writes = number of visible pixels.
- start while busy is ignored. A degenerate line (x1=x2, y1=y2) gives count 1.

Optional Feature:
LINE_CLIP_EN
- Defined: screen clipping as above.
- Undefined: every pixel is visible. The address wraps modulo 2^ADDR_W, and SAMPLE always goes to WRITE.

Decomposition:
- Package line_pkg: state enum (IDLE, CALC, SETTLE, SAMPLE, WRITE, NEXT, DONE), BYTES_PER_PIXEL=4, coordinate typedef coord_t (16-bit).
- One sub-module: fb_addr_calc, a combinational y*SCREEN_W+x shift-and-add with base.

Test Plan:
- (100,90)->(50,100), base 0, waitrequest=0 -> count 51; 51 writes; 50 get_pixel pulses; first address 0x38590; one done pulse.
- Horizontal (10,50)->(20,50) -> 11 writes at addresses 128040..128080 step 4; done.
- Point (10,5)->(10,5), base 0x1000 -> one write to 0x1000+12840; 0 get_pixel pulses.
- waitrequest held for 3 cycles on the first write -> mem_write high for 4 cycles; address and data stable throughout; no get_pixel during the stall.
- Clip with LINE_CLIP_EN, (630,5)->(650,5) -> 21 pixels, 10 writes (x=630..639), 20 get_pixel pulses, done.
- reset low during WRITE of the 3rd pixel -> mem_write, busy and done go 0 immediately; next start runs a full line correctly.
